// File: rtl/serial_adder32_if.sv
// Handshake bundle for serial_adder32: operand side (in_*) and result side (out_*).
// The adder itself connects through the slave modport.
interface serial_adder32_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout
  );
endinterface

// File: rtl/serial_adder32.sv
// Digit-serial adder: DIGIT_W bits of a+b+cin per cycle, LSB digit first, with
// valid/ready handshakes on both sides and a held, registered result.
module serial_adder32 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DIGIT_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  serial_adder32_if.slave bus
);

  localparam int unsigned N    = WIDTH / DIGIT_W;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  // acc holds operand A in its low part and collects finished sum digits at the
  // top, so one register serves as both the A shifter and the sum accumulator.
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [DIGIT_W:0] digit;
  logic [WIDTH-1:0] acc_run;
  logic [WIDTH-1:0] b_shr;
  logic             accept;
  logic             last;
  logic             handoff;

  assign digit = {1'b0, acc_q[DIGIT_W-1:0]} + {1'b0, b_sh_q[DIGIT_W-1:0]}
               + {{DIGIT_W{1'b0}}, carry_q};

  if (DIGIT_W == WIDTH) begin : g_single
    assign acc_run = digit[DIGIT_W-1:0];
    assign b_shr   = '0;
  end else begin : g_multi
    assign acc_run = {digit[DIGIT_W-1:0], acc_q[WIDTH-1:DIGIT_W]};
    assign b_shr   = {{DIGIT_W{1'b0}}, b_sh_q[WIDTH-1:DIGIT_W]};
  end

  assign accept  = (state_q == StIdle) && in_ready_q && bus.in_valid;
  assign last    = (cnt_q == CntW'(N - 1));
  assign handoff = (state_q == StDone) && out_valid_q && bus.out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept)  state_d = StRun;
      StRun:  if (last)    state_d = StDone;
      StDone: if (handoff) state_d = StIdle;
      default:             state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    acc_d       = acc_q;
    b_sh_d      = b_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        in_ready_d = 1'b1;
        if (accept) begin
          acc_d      = bus.a;
          b_sh_d     = bus.b;
          carry_d    = bus.cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
        end
      end
      StRun: begin
        acc_d   = acc_run;
        b_sh_d  = b_shr;
        carry_d = digit[DIGIT_W];
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          sum_d       = acc_run;
          cout_d      = digit[DIGIT_W];
          out_valid_d = 1'b1;
        end
      end
      StDone: begin
        if (handoff) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q       <= '0;
      b_sh_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      b_sh_q      <= b_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_serial_adder32.sv
// Directed and random checks of serial_adder32 at DIGIT_W = 4, 1 and 32
// (instances 0, 1, 2), all sharing one clock and reset.
module tb_serial_adder32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        drv_valid [3];
  logic        drv_cin   [3];
  logic        drv_ordy  [3];
  logic [31:0] drv_a     [3];
  logic [31:0] drv_b     [3];
  logic        obs_rdy   [3];
  logic        obs_ov    [3];
  logic        obs_cout  [3];
  logic [31:0] obs_sum   [3];
  logic [32:0] prev      [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DW = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    serial_adder32_if #(.WIDTH(32)) bus ();
    serial_adder32 #(.WIDTH(32), .DIGIT_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign bus.in_valid  = drv_valid[g];
    assign bus.a         = drv_a[g];
    assign bus.b         = drv_b[g];
    assign bus.cin       = drv_cin[g];
    assign bus.out_ready = drv_ordy[g];
    assign obs_rdy[g]    = bus.in_ready;
    assign obs_ov[g]     = bus.out_valid;
    assign obs_sum[g]    = bus.sum;
    assign obs_cout[g]   = bus.cout;
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 32 : 1);
  endfunction

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transaction on instance k; hold = cycles of back-pressure after out_valid.
  task automatic run_add(input int k, input logic [31:0] av, input logic [31:0] bv,
                         input logic ci, input logic [31:0] es, input logic ec,
                         input bit rnd, input int hold);
    int  n;
    bit  done;
    n = 0;
    while (!obs_rdy[k] && n < 200) begin
      tick();
      n++;
    end
    check("in_ready_before_accept", 33'(obs_rdy[k]), 33'd1);
    drv_valid[k] = 1'b1;
    drv_a[k]     = av;
    drv_b[k]     = bv;
    drv_cin[k]   = ci;
    tick();
    drv_valid[k] = 1'b0;
    drv_a[k]     = $urandom;
    drv_b[k]     = $urandom;
    drv_cin[k]   = 1'($urandom);
    check("in_ready_low_in_run", 33'(obs_rdy[k]), 33'd0);
    check("result_held_in_run", {obs_cout[k], obs_sum[k]}, prev[k]);
    n = 0;
    while (!obs_ov[k] && n < 100) begin
      tick();
      n++;
      drv_a[k] = $urandom;
    end
    check("latency", 33'(n), 33'(lat_of(k)));
    check("sum", 33'(obs_sum[k]), 33'(es));
    check("cout", 33'(obs_cout[k]), 33'(ec));
    check("in_ready_low_done", 33'(obs_rdy[k]), 33'd0);
    prev[k] = {ec, es};
    for (int i = 0; i < hold; i++) begin
      drv_ordy[k] = 1'b0;
      drv_a[k]    = $urandom;
      drv_b[k]    = $urandom;
      drv_valid[k] = 1'($urandom);
      tick();
      check("bp_result", {obs_cout[k], obs_sum[k]}, prev[k]);
      check("bp_out_valid", 33'(obs_ov[k]), 33'd1);
      check("bp_in_ready", 33'(obs_rdy[k]), 33'd0);
    end
    drv_valid[k] = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      drv_ordy[k] = rnd ? 1'($urandom) : 1'b1;
      tick();
      n++;
      if (drv_ordy[k]) done = 1'b1;
      else check("hold_result", {obs_cout[k], obs_sum[k]}, prev[k]);
    end
    drv_ordy[k] = 1'b0;
    check("handoff", 33'(done), 33'd1);
    check("out_valid_cleared", 33'(obs_ov[k]), 33'd0);
    check("in_ready_after_handoff", 33'(obs_rdy[k]), 33'd1);
    check("result_after_handoff", {obs_cout[k], obs_sum[k]}, prev[k]);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [32:0] gold;

    for (int k = 0; k < 3; k++) begin
      drv_valid[k] = 1'b0;
      drv_cin[k]   = 1'b0;
      drv_ordy[k]  = 1'b0;
      drv_a[k]     = '0;
      drv_b[k]     = '0;
      prev[k]      = '0;
    end

    // Reset held for three edges with in_valid asserted
    rst_n        = 1'b0;
    drv_valid[0] = 1'b1;
    drv_a[0]     = 32'h1234_5678;
    drv_b[0]     = 32'h0000_0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_in_ready", 33'(obs_rdy[0]), 33'd0);
      check("rst_out_valid", 33'(obs_ov[0]), 33'd0);
      check("rst_result", {obs_cout[0], obs_sum[0]}, 33'd0);
    end
    check("rst_in_ready_dw1", 33'(obs_rdy[1]), 33'd0);
    check("rst_in_ready_dw32", 33'(obs_rdy[2]), 33'd0);
    drv_valid[0] = 1'b0;
    rst_n        = 1'b1;
    tick();
    check("in_ready_after_release", 33'(obs_rdy[0]), 33'd1);
    check("no_capture_ov", 33'(obs_ov[0]), 33'd0);
    tick();
    check("idle_in_ready", 33'(obs_rdy[0]), 33'd1);
    check("idle_out_valid", 33'(obs_ov[0]), 33'd0);

    // Directed adds, DIGIT_W = 4
    run_add(0, 32'd5, 32'd7, 1'b1, 32'd13, 1'b0, 1'b0, 0);
    run_add(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_add(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
    run_add(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 0);
    run_add(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0);

    // Back-pressure: 20 cycles with out_ready low and inputs wiggling
    run_add(0, 32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 32'hEFBE_D000, 1'b0, 1'b0, 20);
    tick();
    check("bp_back_idle_ov", 33'(obs_ov[0]), 33'd0);
    check("bp_back_idle_rdy", 33'(obs_rdy[0]), 33'd1);

    // Reset landing on RUN digit 3
    drv_valid[0] = 1'b1;
    drv_a[0]     = 32'h0F0F_0F0F;
    drv_b[0]     = 32'h7070_7070;
    drv_cin[0]   = 1'b1;
    tick();
    drv_valid[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 33'(obs_ov[0]), 33'd0);
    check("midrst_in_ready", 33'(obs_rdy[0]), 33'd0);
    check("midrst_result", {obs_cout[0], obs_sum[0]}, 33'd0);
    for (int k = 0; k < 3; k++) prev[k] = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("midrst_no_out_valid", 33'(obs_ov[0]), 33'd0);
    end
    run_add(0, 32'd1, 32'd2, 1'b0, 32'd3, 1'b0, 1'b0, 0);

    // Directed adds, DIGIT_W = 1 and DIGIT_W = 32
    for (int k = 1; k < 3; k++) begin
      run_add(k, 32'd5, 32'd7, 1'b1, 32'd13, 1'b0, 1'b0, 0);
      run_add(k, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 0);
      run_add(k, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0);
      run_add(k, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 3);
    end

    // Random regression against a+b+cin
    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rc   = 1'($urandom);
      gold = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      run_add(0, ra, rb, rc, gold[31:0], gold[32], 1'b1, 0);
    end
    for (int k = 1; k < 3; k++) begin
      for (int i = 0; i < 150; i++) begin
        ra   = $urandom;
        rb   = $urandom;
        rc   = 1'($urandom);
        gold = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
        run_add(k, ra, rb, rc, gold[31:0], gold[32], 1'b1, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
